// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 5x4 matrix keypad scanner with row sync, debounce and newkey/keycode output
module keypad_scanner #(
    parameter int SCAN_DIV   = 4,
    parameter int DEBOUNCE_N = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [4:0] col_n,
    output logic       newkey,
    output logic [4:0] keycode
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;

    logic [3:0]       row_s1;
    logic [3:0]       row_s2;
    logic [DIV_W-1:0] div;
    logic [2:0]       col_idx;
    logic [1:0]       state;
    logic [1:0]       cand_row;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rel_cnt;

    logic             sample;
    logic             hit;
    logic [1:0]       hit_row;
    logic [2:0]       col_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rel_inc;

    assign sample   = (div == DIV_LAST);
    assign hit      = ~&row_s2;
    assign col_next = (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
    assign cnt_inc  = cnt + CNT_ONE;
    assign rel_inc  = rel_cnt + CNT_ONE;
    assign col_n    = ~(5'b00001 << col_idx);

    // Lowest-numbered pressed row wins when several rows in a column are low.
    always_comb begin
        hit_row = 2'd0;
        if (!row_s2[0])
            hit_row = 2'd0;
        else if (!row_s2[1])
            hit_row = 2'd1;
        else if (!row_s2[2])
            hit_row = 2'd2;
        else if (!row_s2[3])
            hit_row = 2'd3;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_s1   <= 4'b1111;
            row_s2   <= 4'b1111;
            div      <= '0;
            col_idx  <= 3'd0;
            state    <= S_SCAN;
            cand_row <= 2'd0;
            cnt      <= '0;
            rel_cnt  <= '0;
            newkey   <= 1'b0;
            keycode  <= 5'd0;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            newkey <= 1'b0;
            div    <= sample ? '0 : div + 1'b1;

            if (sample) begin
                case (state)
                    S_SCAN: begin
                        if (hit) begin
                            cand_row <= hit_row;
                            cnt      <= CNT_ONE;
                            // A single required sample accepts the press on first sight.
                            if (CNT_DONE == CNT_ONE) begin
                                keycode <= {col_idx, hit_row};
                                newkey  <= 1'b1;
                                rel_cnt <= '0;
                                state   <= S_HELD;
                            end else begin
                                state <= S_DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_next;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (hit && (hit_row == cand_row)) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_DONE) begin
                                keycode <= {col_idx, cand_row};
                                newkey  <= 1'b1;
                                rel_cnt <= '0;
                                state   <= S_HELD;
                            end
                        end else begin
                            state   <= S_SCAN;
                            col_idx <= col_next;
                        end
                    end
                    S_HELD: begin
                        if (hit) begin
                            rel_cnt <= '0;
                        end else if (rel_inc == CNT_DONE) begin
                            rel_cnt <= '0;
                            state   <= S_SCAN;
                            col_idx <= col_next;
                        end else begin
                            rel_cnt <= rel_inc;
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_n;
    logic [4:0]  col_n;
    logic        newkey;
    logic [4:0]  keycode;

    logic [19:0] pressed = '0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          pulse_cnt = 0;
    int          exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .row_n   (row_n),
        .col_n   (col_n),
        .newkey  (newkey),
        .keycode (keycode)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !col_n[c])
                    row_n[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (newkey) begin
            int e;
            pulse_cnt++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_pulse: observed keycode %0d expected no pulse", keycode);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_keycode", 32'(keycode), 32'(e));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_col(input string tag, input logic [4:0] target, input int max);
        int n;
        n = 0;
        while (col_n !== target && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(col_n), 32'(target));
    endtask

    task automatic wait_change(input logic [4:0] from, input int max, output int n);
        n = 0;
        while (col_n === from && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_pulse(input string tag, input int target, input int max, output int n);
        n = 0;
        while (pulse_cnt < target && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(pulse_cnt), 32'(target));
    endtask

    initial begin
        int          n;
        int          bad;
        int          base;
        logic [4:0]  e_col;

        // Reset state and free-running scan
        repeat (3) tick();
        check("rst_col_n", 32'(col_n), 32'(5'b11110));
        check("rst_newkey", 32'(newkey), 32'(0));
        check("rst_keycode", 32'(keycode), 32'(0));
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            e_col = ~(5'd1 << ((k / 4) % 5));
            check("scan_col_n", 32'(col_n), 32'(e_col));
        end

        // Key 9 (col 2, row 1) held for 200 cycles
        pressed[9] = 1'b1;
        exp_q.push_back(9);
        wait_pulse("t2_pulse", 1, 100, n);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (col_n !== 5'b11011) bad++;
        end
        check("t2_col_frozen_bad", 32'(bad), 32'(0));
        check("t2_keycode_held", 32'(keycode), 32'(9));
        pressed[9] = 1'b0;
        wait_change(5'b11011, 30, n);
        check("t2_resume_col", 32'(col_n), 32'(5'b10111));
        check("t2_release_lat_ok", 32'(n >= 11 && n <= 14), 32'(1));

        // Bounce on col 3 row 0: two samples low, then released
        wait_col("t3_wait_col2", 5'b11011, 40);
        pressed[12] = 1'b1;
        wait_col("t3_wait_col3", 5'b10111, 40);
        repeat (8) tick();
        pressed[12] = 1'b0;
        base = pulse_cnt;
        repeat (3) tick();
        check("t3_col_still3", 32'(col_n), 32'(5'b10111));
        tick();
        check("t3_next_col", 32'(col_n), 32'(5'b01111));
        repeat (40) tick();
        check("t3_no_pulse", 32'(pulse_cnt), 32'(base));

        // Rows 0 and 2 under col 1; then row 0 released, row 2 held
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        exp_q.push_back(4);
        wait_pulse("t4_pulse", 2, 100, n);
        pressed[4] = 1'b0;
        base = pulse_cnt;
        repeat (40) tick();
        check("t4_still_held_col", 32'(col_n), 32'(5'b11101));
        check("t4_no_pulse", 32'(pulse_cnt), 32'(base));
        pressed[6] = 1'b0;
        wait_change(5'b11101, 30, n);
        check("t4_resume_col", 32'(col_n), 32'(5'b11011));
        check("t4_release_lat_ok", 32'(n >= 11 && n <= 14), 32'(1));

        // Key 19 then key 0
        pressed[19] = 1'b1;
        exp_q.push_back(19);
        wait_pulse("t5_pulse19", 3, 100, n);
        pressed[19] = 1'b0;
        wait_change(5'b01111, 30, n);
        check("t5_col_after_19", 32'(col_n), 32'(5'b11110));
        check("t5_keycode_hold19", 32'(keycode), 32'(19));
        pressed[0] = 1'b1;
        exp_q.push_back(0);
        wait_pulse("t5_pulse0", 4, 100, n);
        pressed[0] = 1'b0;
        wait_change(5'b11110, 30, n);
        check("t5_col_after_0", 32'(col_n), 32'(5'b11101));

        // Reset after the second debounce sample of key 11 (col 2, row 3)
        wait_col("t6_wait_col1", 5'b11101, 40);
        pressed[11] = 1'b1;
        wait_col("t6_wait_col2", 5'b11011, 40);
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check("t6_rst_col_n", 32'(col_n), 32'(5'b11110));
        check("t6_rst_newkey", 32'(newkey), 32'(0));
        check("t6_rst_keycode", 32'(keycode), 32'(0));
        tick();
        reset = 1'b1;
        exp_q.push_back(11);
        wait_pulse("t6_pulse", 5, 60, n);
        check("t6_pulse_latency", 32'(n), 32'(20));
        pressed[11] = 1'b0;
        repeat (30) tick();

        check("final_queue_empty", 32'(exp_q.size()), 32'(0));
        check("final_pulse_count", 32'(pulse_cnt), 32'(5));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
